// File: rtl/lsa_pkg.sv
// Shared constants, state encoding and address helper for the four-channel serial ADC sequencer.
package lsa_pkg;

  localparam int unsigned FRAME_LEN      = 16;
  localparam int unsigned DATA_W         = 12;
  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned FIRST_DATA_BIT = 4;

  localparam int unsigned CNT_W          = $clog2(FRAME_LEN);
  localparam int unsigned CH_W           = $clog2(NUM_CH);
  localparam int unsigned ADDR_W         = 3;
  // Address bits occupy the three counts ending at the first data bit.
  localparam int unsigned ADDR_FIRST     = FIRST_DATA_BIT - ADDR_W + 1;

  typedef enum logic [0:0] {
    GAP   = 1'b0,
    FRAME = 1'b1
  } lsa_state_e;

  // Serial address bit for a given count: zero-extended channel index, MSB first.
  function automatic logic addr_bit(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] cnt);
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  off;
    addr = ADDR_W'(ch);
    off  = CNT_W'(FIRST_DATA_BIT) - cnt;
    if ((cnt >= CNT_W'(ADDR_FIRST)) && (cnt <= CNT_W'(FIRST_DATA_BIT)))
      return addr[off[1:0]];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/lsa_shift_capture.sv
// Single-channel MSB-first serial capture: shift register plus load strobe on the last bit.
module lsa_shift_capture
  import lsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic              i_last,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_word_c,
  output logic              o_load_c
);

  logic [DATA_W-1:0] r_sr;

  // Shift register: cleared between frames, shifts one bit per data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sr <= '0;
    else if (i_clear) r_sr <= '0;
    else if (i_shift) r_sr <= {r_sr[DATA_W-2:0], i_bit};
  end

  // The completed word includes the bit being sampled on the final edge.
  assign o_word_c = {r_sr[DATA_W-2:0], i_bit};
  assign o_load_c = i_shift & i_last;

endmodule

// File: rtl/lsa.sv
// Four-channel serial ADC sequencer: one gap cycle plus a 16-cycle frame per channel, round robin.
module lsa
  import lsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ADC1,
  input  logic              ADC2,
  input  logic              ADC3,
  input  logic              ADC4,
  output logic              din,
  output logic              cs,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] ch2_data,
  output logic [DATA_W-1:0] ch3_data,
  output logic [DATA_W-1:0] ch4_data,
  output logic              data_valid
);

  lsa_state_e        r_state;
  lsa_state_e        w_nxt_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_nxt_count;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   w_nxt_ch;
  logic              r_cs;
  logic              r_din;
  logic              r_valid;
  logic [DATA_W-1:0] r_data [NUM_CH];

  logic              w_adc_bit;
  logic              w_shift;
  logic              w_last;
  logic              w_clear;
  logic [DATA_W-1:0] w_word;
  logic              w_load;

  // Next-state logic: GAP always opens a frame; the frame closes at its last count.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_count = r_count;
    w_nxt_ch    = r_ch;
    case (r_state)
      GAP: begin
        w_nxt_state = FRAME;
        w_nxt_count = '0;
      end
      FRAME: begin
        if (w_last) begin
          w_nxt_state = GAP;
          w_nxt_count = '0;
          w_nxt_ch    = r_ch + CH_W'(1);
        end else begin
          w_nxt_count = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = GAP;
        w_nxt_count = '0;
      end
    endcase
  end

  // State, counter, channel index and the registered serial control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= GAP;
      r_count <= '0;
      r_ch    <= '0;
      r_cs    <= 1'b1;
      r_din   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_count <= w_nxt_count;
      r_ch    <= w_nxt_ch;
      r_cs    <= (w_nxt_state == GAP);
      r_din   <= (w_nxt_state == FRAME) & addr_bit(w_nxt_ch, w_nxt_count);
    end
  end

  // Select the active channel's serial input.
  always_comb begin
    w_adc_bit = 1'b0;
    case (r_ch)
      2'd0:    w_adc_bit = ADC1;
      2'd1:    w_adc_bit = ADC2;
      2'd2:    w_adc_bit = ADC3;
      default: w_adc_bit = ADC4;
    endcase
  end

  assign w_shift = (r_state == FRAME) && (r_count >= CNT_W'(FIRST_DATA_BIT));
  assign w_last  = (r_count == CNT_W'(FRAME_LEN - 1));
  assign w_clear = (r_state == GAP);

  lsa_shift_capture u_capture (
    .clk      (clk),
    .rst_n    (rst),
    .i_clear  (w_clear),
    .i_shift  (w_shift),
    .i_last   (w_last),
    .i_bit    (w_adc_bit),
    .o_word_c (w_word),
    .o_load_c (w_load)
  );

  // Per-channel result registers and the one-cycle update pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) r_data[i] <= '0;
      r_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_load && (r_ch == CH_W'(i))) r_data[i] <= w_word;
      end
      r_valid <= w_load;
    end
  end

  assign cs         = r_cs;
  assign din        = r_din;
  assign count      = r_count;
  assign ch1_data   = r_data[0];
  assign ch2_data   = r_data[1];
  assign ch3_data   = r_data[2];
  assign ch4_data   = r_data[3];
  assign data_valid = r_valid;

endmodule

// File: tb/tb_lsa.sv
// Directed bench for the four-channel serial ADC sequencer.
module tb_lsa;

  logic        clk;
  logic        rst;
  logic        ADC1, ADC2, ADC3, ADC4;
  logic        din;
  logic        cs;
  logic [3:0]  count;
  logic [11:0] ch1_data, ch2_data, ch3_data, ch4_data;
  logic        data_valid;

  int          n_vec;
  int          n_err;
  logic [11:0] exp_data [4];

  lsa dut (
    .clk        (clk),
    .rst        (rst),
    .ADC1       (ADC1),
    .ADC2       (ADC2),
    .ADC3       (ADC3),
    .ADC4       (ADC4),
    .din        (din),
    .cs         (cs),
    .count      (count),
    .ch1_data   (ch1_data),
    .ch2_data   (ch2_data),
    .ch3_data   (ch3_data),
    .ch4_data   (ch4_data),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] get_ch(input int i);
    case (i)
      0:       return ch1_data;
      1:       return ch2_data;
      2:       return ch3_data;
      default: return ch4_data;
    endcase
  endfunction

  task automatic set_adc(input int ch, input logic v);
    case (ch)
      0:       ADC1 = v;
      1:       ADC2 = v;
      2:       ADC3 = v;
      default: ADC4 = v;
    endcase
  endtask

  task automatic chk_data(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_ch%0d_data", tag, i + 1), 32'(get_ch(i)), 32'(exp_data[i]));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cs"},    32'(cs),         32'd1);
    chk({tag, "_count"}, 32'(count),      32'd0);
    chk({tag, "_din"},   32'(din),        32'd0);
    chk({tag, "_dv"},    32'(data_valid), 32'd0);
    chk_data(tag);
  endtask

  // Called at the negedge of a GAP cycle; runs one frame and checks the following GAP.
  task automatic run_frame(input int ch, input logic [11:0] pat, input logic other);
    logic [2:0] addr;
    logic       exp_din;
    addr = 3'(ch);
    ADC1 = other; ADC2 = other; ADC3 = other; ADC4 = other;
    set_adc(ch, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_din = (k >= 2 && k <= 4) ? addr[4-k] : 1'b0;
      chk($sformatf("f%0d_k%0d_cs", ch, k),    32'(cs),         32'd0);
      chk($sformatf("f%0d_k%0d_count", ch, k), 32'(count),      32'(k));
      chk($sformatf("f%0d_k%0d_din", ch, k),   32'(din),        32'(exp_din));
      chk($sformatf("f%0d_k%0d_dv", ch, k),    32'(data_valid), 32'd0);
      if (k >= 4) set_adc(ch, pat[15-k]);
    end
    @(negedge clk);
    exp_data[ch] = pat;
    chk($sformatf("gap%0d_cs", ch),    32'(cs),         32'd1);
    chk($sformatf("gap%0d_count", ch), 32'(count),      32'd0);
    chk($sformatf("gap%0d_din", ch),   32'(din),        32'd0);
    chk($sformatf("gap%0d_dv", ch),    32'(data_valid), 32'd1);
    chk_data($sformatf("gap%0d", ch));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) exp_data[i] = '0;
    rst  = 1'b0;
    ADC1 = 1'b0; ADC2 = 1'b0; ADC3 = 1'b0; ADC4 = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_outs("rst");

    // Release: the gap cycle shows cs=1, count=0.
    rst = 1'b1;
    #1;
    chk("rel_cs",    32'(cs),    32'd1);
    chk("rel_count", 32'(count), 32'd0);

    // Pattern 0x636 on each channel in turn; other inputs held as given.
    run_frame(0, 12'h636, 1'b0);
    run_frame(1, 12'h636, 1'b1);
    run_frame(2, 12'h636, 1'b1);
    run_frame(3, 12'h636, 1'b1);

    // Full scan with all inputs high; the first frame also revisits address 000.
    run_frame(0, 12'hFFF, 1'b1);
    run_frame(1, 12'hFFF, 1'b1);
    run_frame(2, 12'hFFF, 1'b1);
    run_frame(3, 12'hFFF, 1'b1);

    // Abort a frame at count 9 with a reset; nothing partial may survive.
    ADC1 = 1'b1; ADC2 = 1'b0; ADC3 = 1'b0; ADC4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("ab_k%0d_count", k), 32'(count), 32'(k));
      ADC1 = ~ADC1;
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) exp_data[i] = '0;
    chk_reset_outs("abort");
    repeat (2) @(negedge clk);
    chk_reset_outs("abort_hold");

    // Restart and capture a fresh word on channel 1.
    rst = 1'b1;
    #1;
    chk("rel2_cs", 32'(cs), 32'd1);
    run_frame(0, 12'h5A5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
